jcount_checker: RTL and testbench

Receive-side monitor for a free-running Johnson (twisted-ring) counter. Samples the counter's one-hot-free `cnt` pattern every clock and decodes it to a binary state index. Checks code legality and step-to-step sequencing, acquires lock after a run of correct steps, and counts errors. Sits beside a Johnson counter on the shared `clk`/`rstN`, as a synthesizable in-system checker and as the self-checking element the counter bench lacks.

---
 rtl/jcount_pkg.sv | 38 +++
 rtl/jcount_decode.sv | 42 ++++
 rtl/jcount_checker.sv | 163 ++++++++++++++++
 tb/tb_jcount_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jcount_pkg.sv
// Shared types and helpers for the Johnson-counter checker: FSM state
// encoding, sequence length and the reference code for each index.
package jcount_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED
    } jc_state_t;

    // Widest counter supported; jc_code returns a vector this wide.
    localparam int JC_MAX_N = 16;

    // Number of distinct codes in an N-bit twisted ring.
    function automatic int jc_len(input int n);
        return 2 * n;
    endfunction

    // Reference code for index k of an n-bit Johnson counter.
    // Bit i of the result corresponds to cnt[i]; bits at or above n are 0.
    // k in 0..n: the lowest k bits are 1 (the ones fill in from cnt[0]).
    // k in n+1..2n-1: the lowest k-n bits are 0 (zeros fill in from cnt[0]).
    function automatic logic [JC_MAX_N-1:0] jc_code(input int k, input int n);
        logic [JC_MAX_N-1:0] code;
        code = '0;
        for (int i = 0; i < JC_MAX_N; i++) begin
            if (i < n) begin
                if (k <= n) begin
                    code[i] = (i < k);
                end else begin
                    code[i] = (i >= k - n);
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/jcount_decode.sv
// Combinational decoder: maps an observed Johnson pattern to its index and
// flags patterns that are not part of the ring.
module jcount_decode
    import jcount_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [0:N-1]               cnt_i,
    output logic                       legal_o,
    output logic [$clog2(2*N)-1:0]     idx_o
);

    localparam int L     = jc_len(N);
    localparam int IDX_W = $clog2(2 * N);

    // True when the observed pattern equals the reference code for index k.
    function automatic logic code_match(input logic [0:N-1] c, input int k);
        logic [JC_MAX_N-1:0] code;
        logic                m;
        code = jc_code(k, N);
        m    = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (c[i] != code[i]) begin
                m = 1'b0;
            end
        end
        return m;
    endfunction

    // Compare against every legal code; at most one can match.
    always_comb begin
        legal_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < L; k++) begin
            if (code_match(cnt_i, k)) begin
                legal_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/jcount_checker.sv
// In-system monitor for a free-running Johnson counter. Decodes each
// sample, checks it against the expected successor (or hold when the
// producer did not advance), acquires lock after a run of correct steps
// and keeps a saturating error count. All outputs are registered.
module jcount_checker
    import jcount_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_RUN = 4,
    parameter int ERR_W    = 8
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [0:N-1]               cnt,
    input  logic                       adv,
    output logic [$clog2(2*N)-1:0]     idx,
    output logic                       idx_vld,
    output logic                       locked,
    output logic                       illegal,
    output logic                       seq_err,
    output logic                       wrap,
    output logic [ERR_W-1:0]           err_cnt
);

    localparam int L     = jc_len(N);
    localparam int IDX_W = $clog2(2 * N);
    localparam int RUN_W = $clog2(LOCK_RUN + 1);

    // Registered state. idx_q doubles as the reference index ("prev"):
    // it only goes stale on an illegal sample, which also drops to
    // UNLOCKED where no reference is needed.
    jc_state_t          state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;
    logic               illegal_q, illegal_d;
    logic               seq_err_q, seq_err_d;
    logic               wrap_q, wrap_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               dec_legal;
    logic [IDX_W-1:0]   dec_idx;
    logic [IDX_W-1:0]   exp_idx;
    logic [RUN_W-1:0]   run_inc;
    logic               correct;

    jcount_decode #(.N(N)) u_decode (
        .cnt_i   (cnt),
        .legal_o (dec_legal),
        .idx_o   (dec_idx)
    );

    // Expected index for this sample: advance modulo L, or hold.
    always_comb begin
        exp_idx = idx_q;
        if (adv) begin
            if (idx_q == IDX_W'(L - 1)) begin
                exp_idx = '0;
            end else begin
                exp_idx = idx_q + IDX_W'(1);
            end
        end
    end

    assign correct = dec_legal && (dec_idx == exp_idx);
    assign run_inc = run_q + RUN_W'(1);

    // Lock FSM, run counter, index tracking and error pulses.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        illegal_d = 1'b0;
        seq_err_d = 1'b0;
        wrap_d    = 1'b0;

        if (!dec_legal) begin
            // Illegal wins over any sequencing verdict; idx holds.
            illegal_d = 1'b1;
            vld_d     = 1'b0;
            state_d   = UNLOCKED;
            run_d     = '0;
        end else begin
            idx_d = dec_idx;
            vld_d = 1'b1;
            case (state_q)
                UNLOCKED: begin
                    // First legal code becomes the reference; never an error.
                    state_d = LOCKING;
                    run_d   = '0;
                end
                LOCKING: begin
                    if (correct) begin
                        if (run_inc == RUN_W'(LOCK_RUN)) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = UNLOCKED;
                        run_d     = '0;
                    end
                end
                LOCKED: begin
                    if (correct) begin
                        wrap_d = adv && (idx_q == IDX_W'(L - 1)) && (dec_idx == '0);
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = UNLOCKED;
                        run_d     = '0;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Error counter: one count per error pulse, sticks at all-ones.
    always_comb begin
        err_d = err_q;
        if ((illegal_d || seq_err_d) && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= UNLOCKED;
            run_q     <= '0;
            idx_q     <= '0;
            vld_q     <= 1'b0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign idx     = idx_q;
    assign idx_vld = vld_q;
    assign locked  = (state_q == LOCKED);
    assign illegal = illegal_q;
    assign seq_err = seq_err_q;
    assign wrap    = wrap_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_jcount_checker.sv
// Directed bench for jcount_checker (N=4, LOCK_RUN=4, ERR_W=3).
// Inputs change on the falling edge; outputs are checked 1 time unit
// after the rising edge that sampled them.
module tb_jcount_checker;
    import jcount_pkg::*;

    logic       clk;
    logic       rstN;
    logic [0:3] cnt;
    logic       adv;
    logic [2:0] idx;
    logic       idx_vld;
    logic       locked;
    logic       illegal;
    logic       seq_err;
    logic       wrap;
    logic [2:0] err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cur    = 0;

    jcount_checker #(.N(4), .LOCK_RUN(4), .ERR_W(3)) dut (
        .clk     (clk),
        .rstN    (rstN),
        .cnt     (cnt),
        .adv     (adv),
        .idx     (idx),
        .idx_vld (idx_vld),
        .locked  (locked),
        .illegal (illegal),
        .seq_err (seq_err),
        .wrap    (wrap),
        .err_cnt (err_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [0:3] pat(input int k);
        logic [JC_MAX_N-1:0] c;
        logic [0:3]          p;
        c = jc_code(k, 4);
        for (int i = 0; i < 4; i++) p[i] = c[i];
        return p;
    endfunction

    // Driver tasks: drive on falling edge (also releases reset), wait for
    // the sampling edge, settle.
    task automatic step_raw(input logic [0:3] c, input logic a);
        @(negedge clk);
        rstN = 1'b1;
        cnt  = c;
        adv  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int k, input logic a);
        step_raw(pat(k), a);
        cur = k;
    endtask

    task automatic advance_to(input int k);
        while (cur != k) step((cur + 1) % 8, 1'b1);
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        cnt  = 4'b0000;
        adv  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (idx !== 3'd0)     begin n_fail++; $display("FAIL reset_idx got %0d want 0", idx); end
        n_cmp++; if (idx_vld !== 1'b0) begin n_fail++; $display("FAIL reset_idx_vld got %b want 0", idx_vld); end
        n_cmp++; if (locked !== 1'b0)  begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
        n_cmp++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
        n_cmp++; if (wrap !== 1'b0)    begin n_fail++; $display("FAIL reset_wrap got %b want 0", wrap); end
        n_cmp++; if (err_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_lock;
        // Reference load, then two correct holds (run=2).
        step(0, 1'b0);
        n_cmp++; if (idx_vld !== 1'b1) begin n_fail++; $display("FAIL lock_first_vld got %b want 1", idx_vld); end
        n_cmp++; if (locked !== 1'b0)  begin n_fail++; $display("FAIL lock_first_locked got %b want 0", locked); end
        step(0, 1'b0);
        step(0, 1'b0);
        n_cmp++; if ((illegal | seq_err) !== 1'b0) begin n_fail++; $display("FAIL lock_hold_err got %b want 0", illegal | seq_err); end
        step(1, 1'b1);  // third correct step
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_3rd got %b want 0", locked); end
        n_cmp++; if (idx !== 3'd1)    begin n_fail++; $display("FAIL lock_idx1 got %0d want 1", idx); end
        step(2, 1'b1);  // fourth correct step
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_4th got %b want 1", locked); end
        n_cmp++; if (idx !== 3'd2)    begin n_fail++; $display("FAIL lock_idx2 got %0d want 2", idx); end
        for (int k = 3; k < 8; k++) begin
            step(k, 1'b1);
            n_cmp++; if (idx !== 3'(k)) begin n_fail++; $display("FAIL lock_track got %0d want %0d", idx, k); end
            n_cmp++; if ({locked, illegal, seq_err, wrap} !== 4'b1000) begin
                n_fail++; $display("FAIL lock_flags got %b want 1000", {locked, illegal, seq_err, wrap});
            end
        end
        n_cmp++; if (err_cnt !== 3'd0) begin n_fail++; $display("FAIL lock_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_wrap;
        int nwrap;
        step(0, 1'b1);  // 0001 -> 0000
        n_cmp++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got %b want 1", wrap); end
        n_cmp++; if (idx !== 3'd0)  begin n_fail++; $display("FAIL wrap_idx got %0d want 0", idx); end
        step(1, 1'b1);
        n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle got %b want 0", wrap); end
        nwrap = 0;
        for (int i = 0; i < 16; i++) begin
            step((cur + 1) % 8, 1'b1);
            if (wrap === 1'b1) nwrap++;
        end
        n_cmp++; if (nwrap != 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", nwrap); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL wrap_locked got %b want 1", locked); end
    endtask

    // Reference load plus four correct steps; locked only after the last.
    task automatic relock(input string name);
        for (int i = 0; i < 5; i++) begin
            step((cur + 1) % 8, 1'b1);
            n_cmp++; if (locked !== (i == 4)) begin
                n_fail++; $display("FAIL %s_relock%0d got %b want %b", name, i, locked, (i == 4));
            end
        end
    endtask

    task automatic test_illegal;
        int held;
        held = cur;
        step_raw(4'b1010, 1'b1);
        n_cmp++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got %b want 1", illegal); end
        n_cmp++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL ill_seq_err got %b want 0", seq_err); end
        n_cmp++; if (idx_vld !== 1'b0) begin n_fail++; $display("FAIL ill_vld got %b want 0", idx_vld); end
        n_cmp++; if (locked !== 1'b0)  begin n_fail++; $display("FAIL ill_locked got %b want 0", locked); end
        n_cmp++; if (err_cnt !== 3'd1) begin n_fail++; $display("FAIL ill_err_cnt got %0d want 1", err_cnt); end
        n_cmp++; if (idx !== 3'(held)) begin n_fail++; $display("FAIL ill_idx_hold got %0d want %0d", idx, held); end
        relock("ill");
        n_cmp++; if ({illegal, seq_err, idx_vld} !== 3'b001) begin
            n_fail++; $display("FAIL ill_after got %b want 001", {illegal, seq_err, idx_vld});
        end
    endtask

    task automatic test_skip_stall;
        advance_to(2);
        step(4, 1'b1);  // 1100 -> 1111 skips 1110
        n_cmp++; if ({seq_err, illegal} !== 2'b10) begin n_fail++; $display("FAIL skip_flags got %b want 10", {seq_err, illegal}); end
        n_cmp++; if (locked !== 1'b0)  begin n_fail++; $display("FAIL skip_locked got %b want 0", locked); end
        n_cmp++; if (err_cnt !== 3'd2) begin n_fail++; $display("FAIL skip_err_cnt got %0d want 2", err_cnt); end
        n_cmp++; if (idx !== 3'd4)     begin n_fail++; $display("FAIL skip_idx got %0d want 4", idx); end
        relock("skip");
        advance_to(3);
        step(3, 1'b1);  // 1110 held while adv=1
        n_cmp++; if ({seq_err, illegal} !== 2'b10) begin n_fail++; $display("FAIL stall_flags got %b want 10", {seq_err, illegal}); end
        n_cmp++; if (err_cnt !== 3'd3) begin n_fail++; $display("FAIL stall_err_cnt got %0d want 3", err_cnt); end
        relock("stall");
        advance_to(5);
        step(6, 1'b0);  // 0111 -> 0011 with adv=0
        n_cmp++; if ({seq_err, illegal} !== 2'b10) begin n_fail++; $display("FAIL move_flags got %b want 10", {seq_err, illegal}); end
        n_cmp++; if (err_cnt !== 3'd4) begin n_fail++; $display("FAIL move_err_cnt got %0d want 4", err_cnt); end
        step(6, 1'b0);  // new reference, no error
        n_cmp++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL move_after got %b want 0", seq_err); end
    endtask

    task automatic test_saturation;
        logic [0:3] bad [10];
        int         want;
        bad = '{4'b1010, 4'b0101, 4'b1001, 4'b0110, 4'b1011,
                4'b1101, 4'b0100, 4'b0010, 4'b1010, 4'b0101};
        #2;
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (err_cnt !== 3'd0) begin n_fail++; $display("FAIL sat_reset got %0d want 0", err_cnt); end
        for (int i = 0; i < 10; i++) begin
            step_raw(bad[i], 1'b1);
            want = (i + 1 > 7) ? 7 : i + 1;
            n_cmp++; if (err_cnt !== 3'(want)) begin n_fail++; $display("FAIL sat_cnt%0d got %0d want %0d", i, err_cnt, want); end
            n_cmp++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL sat_ill%0d got %b want 1", i, illegal); end
        end
    endtask

    task automatic test_midrun_reset;
        cur = 7;
        relock("mid");  // loads 0, locks on 4
        #2;
        rstN = 1'b0;    // between edges
        #1;
        n_cmp++; if ({idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt} !== 11'd0) begin
            n_fail++; $display("FAIL mid_async got %b want 0", {idx, idx_vld, locked, illegal, seq_err, wrap, err_cnt});
        end
        repeat (2) @(posedge clk);
        step(3, 1'b1);  // release; 1110 is the first sample
        n_cmp++; if ({illegal, seq_err, locked} !== 3'b000) begin
            n_fail++; $display("FAIL mid_first got %b want 000", {illegal, seq_err, locked});
        end
        n_cmp++; if (idx !== 3'd3) begin n_fail++; $display("FAIL mid_idx got %0d want 3", idx); end
        for (int k = 4; k < 8; k++) begin
            step(k, 1'b1);
            n_cmp++; if (locked !== (k == 7)) begin n_fail++; $display("FAIL mid_lock%0d got %b want %b", k, locked, (k == 7)); end
        end
        n_cmp++; if (err_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_err_cnt got %0d want 0", err_cnt); end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_illegal();
        test_skip_stall();
        test_saturation();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
